// File: rtl/drbg_stream_ctrl_if.sv
// Hash-core request/acknowledge channel and keystream valid/ready channel.
// master = DRBG sequencer side, slave = hash core / keystream consumer side.
interface drbg_stream_ctrl_if #(
   parameter int OUT_WIDTH = 32
);
   logic                 hash_req;
   logic [511:0]         hash_msg;
   logic                 hash_ack;
   logic [255:0]         hash_digest;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;

   modport master (
      output hash_req, hash_msg, out_valid, out_data,
      input  hash_ack, hash_digest, out_ready
   );

   modport slave (
      input  hash_req, hash_msg, out_valid, out_data,
      output hash_ack, hash_digest, out_ready
   );
endinterface

// File: rtl/drbg_stream_ctrl.sv
// Hash-DRBG sequencer: seeds, generates and reseeds a 256-bit state through an
// external hash core and streams keystream words, with word-skip catch-up.
//
//   state      | meaning
//   IDLE       | unseeded, waiting for init
//   SEED_REQ   | hashing latched seed into V
//   GEN_REQ    | hashing V with gen_counter into the output block
//   SERVE      | emitting / skipping words of the current block
//   RESEED_REQ | hashing V with reseed_counter+1 into the new V
//   DRAIN      | init aborted a request; waiting to discard its digest
module drbg_stream_ctrl #(
   parameter int OUT_WIDTH       = 32,
   parameter int BLOCKS_PER_SEED = 3,
   parameter int CNT_WIDTH       = 64,
   parameter int SKIP_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   drbg_stream_ctrl_if.master    bus,
   input  logic                  init,
   input  logic [255:0]          seed_in,
   input  logic                  skip_load,
   input  logic [SKIP_WIDTH-1:0] skip_count,
   output logic                  skip_busy,
   output logic                  init_ready,
   output logic [CNT_WIDTH-1:0]  reseed_counter,
   output logic [CNT_WIDTH-1:0]  gen_counter
);
   localparam int WORDS = 256 / OUT_WIDTH;
   localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int BW    = $clog2(BLOCKS_PER_SEED + 1);
   localparam logic [IW-1:0]         LAST_IDX = IW'(WORDS - 1);
   localparam logic [IW-1:0]         IDX_ONE  = IW'(1);
   localparam logic [BW-1:0]         BPS      = BW'(BLOCKS_PER_SEED);
   localparam logic [BW-1:0]         BLK_ONE  = BW'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [SKIP_WIDTH-1:0] SKIP_ONE = SKIP_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, SEED_REQ, GEN_REQ, SERVE, RESEED_REQ, DRAIN} state_t;

   state_t                  state, state_nxt;
   logic [255:0]            v, seed_lat, buffer;
   logic [511:0]            drain_msg, msg_cur;
   logic [IW-1:0]           word_idx;
   logic [BW-1:0]           blocks_since_seed;
   logic [SKIP_WIDTH-1:0]   skip_left;
   logic [CNT_WIDTH-1:0]    reseed_next;
   logic                    req, consume, last_word, init_abort;

   assign req         = state inside {SEED_REQ, GEN_REQ, RESEED_REQ, DRAIN};
   assign skip_busy   = (skip_left != '0);
   assign consume     = (state == SERVE) && (skip_busy || bus.out_ready);
   assign last_word   = (word_idx == LAST_IDX);
   assign init_abort  = init && (state != IDLE) && (state != DRAIN);
   assign reseed_next = reseed_counter + CNT_ONE;

   assign bus.hash_req  = req;
   assign bus.hash_msg  = msg_cur;
   assign bus.out_valid = (state == SERVE) && !skip_busy;
   assign bus.out_data  = buffer[OUT_WIDTH-1:0];

   // DRAIN replays a snapshot so the message cannot move while its request is open.
   always_comb begin
      msg_cur = '0;
      case (state)
         SEED_REQ:   msg_cur = {seed_lat, 8'h02, 248'd0};
         GEN_REQ:    msg_cur = {v, 8'h00, 184'd0, 64'(gen_counter)};
         RESEED_REQ: msg_cur = {v, 8'h01, 184'd0, 64'(reseed_next)};
         DRAIN:      msg_cur = drain_msg;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (init_abort) begin
         state_nxt = (req && !bus.hash_ack) ? DRAIN : SEED_REQ;
      end else begin
         case (state)
            IDLE:       if (init) state_nxt = SEED_REQ;
            SEED_REQ:   if (bus.hash_ack) state_nxt = GEN_REQ;
            GEN_REQ:    if (bus.hash_ack) state_nxt = SERVE;
            SERVE:      if (consume && last_word)
                           state_nxt = (blocks_since_seed == BPS) ? RESEED_REQ : GEN_REQ;
            RESEED_REQ: if (bus.hash_ack) state_nxt = GEN_REQ;
            DRAIN:      if (bus.hash_ack) state_nxt = SEED_REQ;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v                 <= '0;
         seed_lat          <= '0;
         buffer            <= '0;
         drain_msg         <= '0;
         word_idx          <= '0;
         blocks_since_seed <= '0;
         skip_left         <= '0;
         init_ready        <= 1'b0;
         gen_counter       <= '0;
         reseed_counter    <= '0;
      end else begin
         if (init) seed_lat <= seed_in;
         if (init_abort) begin
            buffer     <= '0;
            skip_left  <= '0;
            init_ready <= 1'b0;
            drain_msg  <= msg_cur;
         end else begin
            case (state)
               SEED_REQ: if (bus.hash_ack) begin
                  v                 <= bus.hash_digest;
                  gen_counter       <= '0;
                  reseed_counter    <= '0;
                  blocks_since_seed <= '0;
                  init_ready        <= 1'b1;
               end
               GEN_REQ: if (bus.hash_ack) begin
                  buffer            <= bus.hash_digest;
                  word_idx          <= '0;
                  gen_counter       <= gen_counter + CNT_ONE;
                  blocks_since_seed <= blocks_since_seed + BLK_ONE;
               end
               SERVE: if (consume) begin
                  buffer   <= buffer >> OUT_WIDTH;
                  word_idx <= word_idx + IDX_ONE;
               end
               RESEED_REQ: if (bus.hash_ack) begin
                  v                 <= bus.hash_digest;
                  reseed_counter    <= reseed_next;
                  blocks_since_seed <= '0;
               end
               default: ;
            endcase
            // A load is only accepted when idle, so it always starts after any word
            // transferred on the same edge.
            if (skip_busy) begin
               if (consume) skip_left <= skip_left - SKIP_ONE;
            end else if (skip_load) begin
               skip_left <= skip_count;
            end
         end
      end
   end
endmodule

// File: tb/tb_drbg_stream_ctrl.sv
// Scoreboard bench for drbg_stream_ctrl: a reference DRBG model fills expected
// message/word queues; the hash responder and stream monitor pop and compare.
module tb_drbg_stream_ctrl;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          init = 1'b0;
   logic [255:0]  seed_in = '0;
   logic          skip_load = 1'b0;
   logic [15:0]   skip_count = '0;
   logic          skip_busy, init_ready;
   logic [63:0]   reseed_counter, gen_counter;

   always #5 clk = ~clk;

   drbg_stream_ctrl_if #(.OUT_WIDTH(W)) bus ();

   drbg_stream_ctrl #(
      .OUT_WIDTH(W), .BLOCKS_PER_SEED(3), .CNT_WIDTH(64), .SKIP_WIDTH(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .init(init), .seed_in(seed_in),
      .skip_load(skip_load), .skip_count(skip_count), .skip_busy(skip_busy),
      .init_ready(init_ready), .reseed_counter(reseed_counter), .gen_counter(gen_counter)
   );

   int             checks = 0;
   int             errors = 0;
   int             words_seen = 0;
   int             hash_lat = 2;
   logic [511:0]   exp_msgs[$];
   logic [W-1:0]   exp_words[$];

   function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [255:0] hfn(input logic [511:0] m);
      return m[511:256] ^ {m[247:0], m[255:248]};
   endfunction

   function automatic logic [511:0] seed_msg(input logic [255:0] s);
      return {s, 8'h02, 248'd0};
   endfunction

   function automatic logic [511:0] gen_msg(input logic [255:0] v, input logic [63:0] c);
      return {v, 8'h00, 184'd0, c};
   endfunction

   function automatic logic [511:0] rs_msg(input logic [255:0] v, input logic [63:0] c);
      return {v, 8'h01, 184'd0, c};
   endfunction

   // Reference sequence after a seed: messages in request order, emitted words in
   // order, with word indices [skip_start, skip_start+skip_n) dropped.
   task automatic model_push(input logic [255:0] seed, input int nblocks,
                             input int skip_start, input int skip_n);
      logic [255:0] v, blk;
      logic [511:0] m;
      logic [63:0]  gc, rc;
      int           bss, idx;
      m = seed_msg(seed);
      exp_msgs.push_back(m);
      v = hfn(m); gc = '0; rc = '0; bss = 0; idx = 0;
      for (int b = 0; b < nblocks; b++) begin
         m = gen_msg(v, gc);
         exp_msgs.push_back(m);
         blk = hfn(m);
         gc++; bss++;
         for (int w = 0; w < 256 / W; w++) begin
            if (idx < skip_start || idx >= skip_start + skip_n)
               exp_words.push_back(blk[w*W +: W]);
            idx++;
         end
         if (bss == 3) begin
            rc++;
            m = rs_msg(v, rc);
            exp_msgs.push_back(m);
            v = hfn(m);
            bss = 0;
         end
      end
   endtask

   // Hash core model: acks after hash_lat request cycles, only when a message is expected.
   initial begin : responder
      int           cnt;
      logic         prev_req;
      logic [511:0] prev_msg;
      cnt = 0; prev_req = 1'b0; prev_msg = '0;
      bus.hash_ack = 1'b0;
      bus.hash_digest = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            cnt = 0; bus.hash_ack = 1'b0; prev_req = 1'b0;
         end else if (bus.hash_ack) begin
            bus.hash_ack = 1'b0; cnt = 0; prev_req = 1'b0;
         end else begin
            if (prev_req && bus.hash_req) chk("msg_stable", bus.hash_msg, prev_msg);
            prev_req = bus.hash_req;
            prev_msg = bus.hash_msg;
            if (bus.hash_req && exp_msgs.size() > 0) begin
               cnt++;
               if (cnt >= hash_lat) begin
                  chk("hash_msg", bus.hash_msg, exp_msgs.pop_front());
                  bus.hash_digest = hfn(bus.hash_msg);
                  bus.hash_ack = 1'b1;
               end
            end else begin
               cnt = 0;
            end
         end
      end
   end

   initial begin : monitor
      logic         pv, pr;
      logic [W-1:0] pd;
      pv = 1'b0; pr = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               chk("hold_valid", 512'(bus.out_valid), 512'(1));
               chk("hold_data", 512'(bus.out_data), 512'(pd));
            end
            if (skip_busy) chk("valid_while_skip", 512'(bus.out_valid), 512'(0));
            if (bus.out_valid && bus.out_ready) begin
               if (exp_words.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL word: got unexpected %0h expected none", bus.out_data);
               end else begin
                  chk("word", 512'(bus.out_data), 512'(exp_words.pop_front()));
               end
               words_seen++;
            end
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; init = 1'b0; skip_load = 1'b0; bus.out_ready = 1'b1;
      exp_msgs.delete(); exp_words.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic pulse_init(input logic [255:0] s);
      seed_in = s; init = 1'b1;
      tick();
      init = 1'b0;
   endtask

   task automatic wait_words(input int target);
      int n = 0;
      while (words_seen < target && n < 2000) begin tick(); n++; end
      if (words_seen < target) begin
         checks++; errors++;
         $display("FAIL wait_words: seen %0d need %0d", words_seen, target);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!init_ready && n < 500) begin tick(); n++; end
      if (!init_ready) begin
         checks++; errors++;
         $display("FAIL wait_ready: init_ready %0b need 1", init_ready);
      end
   endtask

   task automatic wait_valid_rise();
      int n = 0;
      while (bus.out_valid && n < 500) begin tick(); n++; end
      while (!bus.out_valid && n < 500) begin tick(); n++; end
      if (!bus.out_valid) begin
         checks++; errors++;
         $display("FAIL wait_valid: out_valid %0b need 1", bus.out_valid);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_hash_req"}, 512'(bus.hash_req), 512'(0));
      chk({tag, "_hash_msg"}, bus.hash_msg, 512'(0));
      chk({tag, "_out_valid"}, 512'(bus.out_valid), 512'(0));
      chk({tag, "_out_data"}, 512'(bus.out_data), 512'(0));
      chk({tag, "_skip_busy"}, 512'(skip_busy), 512'(0));
      chk({tag, "_init_ready"}, 512'(init_ready), 512'(0));
      chk({tag, "_reseed_cnt"}, 512'(reseed_counter), 512'(0));
      chk({tag, "_gen_cnt"}, 512'(gen_counter), 512'(0));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int base;
      bus.out_ready = 1'b1;
      repeat (2) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Seed and stream through one reseed.
      hash_lat = 2;
      base = words_seen;
      model_push(256'h1, 4, 0, 0);
      pulse_init(256'h1);
      for (int b = 1; b <= 4; b++) begin
         wait_valid_rise();
         chk("gen_counter", 512'(gen_counter), 512'(b));
         chk("reseed_counter", 512'(reseed_counter), 512'((b == 4) ? 1 : 0));
         chk("init_ready", 512'(init_ready), 512'(1));
         wait_words(base + 8 * b);
      end

      // Catch-up skip of 10 words; loads while busy and loads of 0 are ignored.
      do_reset();
      base = words_seen;
      model_push(256'h1, 3, 0, 10);
      pulse_init(256'h1);
      wait_ready();
      skip_count = 16'd10; skip_load = 1'b1;
      tick();
      skip_load = 1'b0;
      chk("skip_busy_set", 512'(skip_busy), 512'(1));
      skip_count = 16'd5; skip_load = 1'b1;
      tick();
      skip_load = 1'b0;
      wait_words(base + 1);
      chk("skip_busy_done", 512'(skip_busy), 512'(0));
      skip_count = 16'd0; skip_load = 1'b1;
      tick();
      skip_load = 1'b0;
      chk("skip_zero_load", 512'(skip_busy), 512'(0));
      wait_words(base + 14);

      // Backpressure hold, then a skip load coinciding with a transfer.
      do_reset();
      base = words_seen;
      model_push(256'h5a5a, 4, 13, 3);
      pulse_init(256'h5a5a);
      wait_words(base + 3);
      bus.out_ready = 1'b0;
      repeat (5) tick();
      bus.out_ready = 1'b1;
      wait_words(base + 12);
      skip_count = 16'd3; skip_load = 1'b1;
      tick();
      skip_load = 1'b0;
      wait_words(base + 24);

      // init while a gen request is outstanding: its digest is drained and discarded.
      do_reset();
      hash_lat = 3;
      base = words_seen;
      exp_msgs.push_back(seed_msg(256'hA1));
      exp_msgs.push_back(gen_msg(hfn(seed_msg(256'hA1)), 64'd0));
      model_push(256'hB2, 2, 0, 0);
      pulse_init(256'hA1);
      wait_ready();
      chk("gen_req_open", 512'(bus.hash_req), 512'(1));
      pulse_init(256'hB2);
      chk("drain_init_ready", 512'(init_ready), 512'(0));
      chk("drain_req", 512'(bus.hash_req), 512'(1));
      repeat (3) tick();
      chk("post_drain_init_ready", 512'(init_ready), 512'(0));
      chk("post_drain_seed_msg", bus.hash_msg, seed_msg(256'hB2));
      wait_ready();
      chk("reseeded_gen_cnt", 512'(gen_counter), 512'(0));
      wait_words(base + 16);

      // Asynchronous reset mid-SERVE, then the same seed reproduces the stream.
      hash_lat = 2;
      do_reset();
      base = words_seen;
      model_push(256'h1, 2, 0, 0);
      pulse_init(256'h1);
      wait_words(base + 4);
      #2 reset = 1'b1;
      #1 check_all_zero("async");
      do_reset();
      base = words_seen;
      model_push(256'h1, 2, 0, 0);
      pulse_init(256'h1);
      wait_words(base + 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/drbg_stream_ctrl.md
# drbg_stream_ctrl

- Parametrised hash-DRBG sequencer. Seeds, generates and reseeds a 256-bit DRBG state through an external SHA-256 core using a request/acknowledge handshake.
- Delivers keystream as OUT_WIDTH-bit words on a valid/ready stream.
- Supports catch-up: a loadable skip counter discards words so a slave descrambler can realign with the master's word index.
- Sits between the hash core and the video scrambler/descrambler datapath. Generalises the fixed 256-bit, cycle-count-limited generator to arbitrary word width and reseed interval.

## Interface
- OUT_WIDTH, 32, keystream word width; must divide 256 (8, 16, 32, 64, 128, 256).
- BLOCKS_PER_SEED, 3, generated 256-bit blocks between reseeds; ≥1.
- CNT_WIDTH, 64, width of the generate and reseed counters; ≤64.
- SKIP_WIDTH, 16, width of the skip count.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  one-cycle pulse; (re)seeds from seed_in.
- seed_in  in  256  seed material; sampled on the cycle init is high.
- hash_req  out  1  request to the hash core; held until hash_ack.
- hash_msg  out  512  message block; stable while hash_req is high.
- hash_ack  in  1  one-cycle pulse; hash_digest is valid in the same cycle.
- hash_digest  in  256  digest.
- out_valid  out  1  keystream word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_WIDTH  keystream word.
- skip_load  in  1  pulse; loads skip_count.
- skip_count  in  SKIP_WIDTH  number of words to discard.
- skip_busy  out  1  skip in progress.
- init_ready  out  1  high once seeded; low while unseeded or reseeding after init.
- reseed_counter  out  CNT_WIDTH  completed reseeds since init.
- gen_counter  out  CNT_WIDTH  blocks generated since init.

## Operation
- States: IDLE, SEED_REQ, GEN_REQ, SERVE, RESEED_REQ, DRAIN.
  - Each *_REQ state asserts hash_req and holds it until hash_ack.
- Message formats (concatenation, MSB first, 512 bits):
  - seed: {seed_in_latched, 8'h02, 248'd0}.
  - gen: {V, 8'h00, 184'd0, gen_counter zero-extended to 64}.
  - reseed: {V, 8'h01, 184'd0, reseed_counter+1 zero-extended to 64}.
- IDLE: only init is acted on. init → latch seed_in, go to SEED_REQ.
- SEED_REQ, on ack:
  - V←digest; clear gen_counter, reseed_counter and blocks_since_seed.
  - init_ready←1; go to GEN_REQ.
- GEN_REQ, on ack:
  - buffer←digest; word index←0; gen_counter+1 (wraps); blocks_since_seed+1; go to SERVE.
- SERVE: out_data = buffer word at the word index, LSB word first (bits [OUT_WIDTH-1:0] are word 0).
  - A word is consumed either by an out_valid&&out_ready transfer, or, when skip is active, internally at one per cycle with out_valid forced low.
  - After the last word (index 256/OUT_WIDTH−1):
    - if blocks_since_seed==BLOCKS_PER_SEED, go to RESEED_REQ;
    - otherwise go to GEN_REQ.
- RESEED_REQ, on ack: V←digest; reseed_counter+1 (wraps); blocks_since_seed←0; go to GEN_REQ.
- Skip:
  - skip_load loads the count only when skip_busy=0; a load while busy is ignored.
  - A load of 0 has no effect.
  - skip_busy stays high until the count reaches 0; the count decrements on each discarded word.
  - Skipping continues across block and reseed boundaries; no words are emitted while busy.
- init while not IDLE:
  - latch seed_in; clear the buffer, the skip count and init_ready.
  - If hash_req is high, go to DRAIN, wait for hash_ack, discard the digest, then go to SEED_REQ.
  - Otherwise go directly to SEED_REQ.
  - init during DRAIN re-latches seed_in only.

## Timing
- Reset values:
  - hash_req=0, hash_msg=0, out_valid=0, out_data=0, skip_busy=0, init_ready=0, both counters 0.
  - State IDLE, V=0.
- init high at edge n → hash_req high at n+1.
- hash_ack at edge n → next hash_req at n+1 (for SEED and RESEED), or out_valid at n+1 (for GEN).
- Last word consumed at edge n → hash_req high at n+1; out_valid low from n+1 until the next block arrives.
- hash_req asserts only from a registered state; the message never changes while hash_req is high.
- Backpressure: while out_valid=1 and out_ready=0, out_data holds.
- init and hash_ack in the same cycle: init wins; the digest is discarded and the next request is a seed request.
- skip_load arriving on the same edge that a word is transferred: the transfer completes, and skipping starts with the following word.

## Test plan
- Seed and stream, using a bench hash model with digest = msg[511:256] ^ {msg[255:0] rotated left by 8}:
  - init with seed_in=256'h1 → 8 words per block (OUT_WIDTH=32).
  - gen_counter goes 1, 2, 3.
  - hash_msg[63:0] on gen requests = 0, 1, 2.
- Reseed: after 24 words → a reseed request with hash_msg[255:248]=8'h01 and hash_msg[63:0]=1.
  - reseed_counter=1 after its ack.
  - The next gen request carries the new V.
- Catch-up: skip_count=10 right after init_ready → skip_busy high for 10 consumed words.
  - The first emitted word equals block 1, word 2 of the unskipped run.
- Backpressure: out_ready held low for 5 cycles mid-block → out_data stable throughout; no word lost or duplicated over 24 words.
- Init during a gen wait (hash_req=1):
  - hash_ack arriving 3 cycles later is discarded.
  - The next request is a seed message.
  - init_ready is low until the seed ack.
- Async reset mid-SERVE → all outputs 0 immediately, without a clock edge; a subsequent init reproduces the original keystream.
